// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a common-anode 7-segment display with tear-free frame
// loading, leading-zero blanking, decimal points, ghosting guard and PWM dimming.
module seven_seg_scanner #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned BLANK_CYCLES = 2,
    parameter int unsigned DIM_WIDTH    = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [4*NUM_DIGITS-1:0]   value_i,
    input  logic [NUM_DIGITS-1:0]     dp_mask_i,
    input  logic                      load_i,
    input  logic                      blank_lz_i,
    input  logic [DIM_WIDTH-1:0]      brightness_i,
    output logic [6:0]                seg_o,
    output logic                      dp_o,
    output logic [NUM_DIGITS-1:0]     an_o,
    output logic                      scan_done_o
);
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam int unsigned VW = 4 * NUM_DIGITS;

    logic [PW-1:0]         p_q, p_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DIM_WIDTH-1:0]  pwm_q;
    logic [VW-1:0]         pend_val_q, act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  scan_done_q;

    logic                  p_wrap, idx_last, frame_end, pwm_on, en;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  upper_zero;
    logic [3:0]            digit;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0001100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Digit k is a leading zero when it and every digit above it are zero.
    always_comb begin
        lz_blank   = '0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            upper_zero  = upper_zero & (act_val_q[4*k +: 4] == 4'h0);
            lz_blank[k] = blank_lz_i & upper_zero;
        end
    end

    always_comb begin
        p_wrap    = (p_q == PW'(PRESCALE - 1));
        idx_last  = (idx_q == IW'(NUM_DIGITS - 1));
        frame_end = p_wrap & idx_last;
        p_d       = p_wrap ? '0 : p_q + 1'b1;
        idx_d     = idx_q;
        if (p_wrap) begin
            idx_d = idx_last ? '0 : idx_q + 1'b1;
        end

        // A load coinciding with the frame boundary goes straight into the new frame.
        act_val_d = act_val_q;
        act_dp_d  = act_dp_q;
        if (frame_end) begin
            act_val_d = load_i ? value_i   : pend_val_q;
            act_dp_d  = load_i ? dp_mask_i : pend_dp_q;
        end

        pwm_on = (brightness_i == '1) | (pwm_q < brightness_i);
        en     = (p_q >= PW'(BLANK_CYCLES)) & pwm_on & ~lz_blank[idx_q];
        digit  = act_val_q[{idx_q, 2'b00} +: 4];

        an_d  = en ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        seg_d = lz_blank[idx_q] ? 7'h7F : seg_decode(digit);
        dp_d  = ~act_dp_q[idx_q];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p_q         <= '0;
            idx_q       <= '0;
            pwm_q       <= '0;
            pend_val_q  <= '0;
            pend_dp_q   <= '0;
            act_val_q   <= '0;
            act_dp_q    <= '0;
            an_q        <= '1;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            scan_done_q <= 1'b0;
        end else begin
            p_q         <= p_d;
            idx_q       <= idx_d;
            pwm_q       <= pwm_q + 1'b1;
            if (load_i) begin
                pend_val_q <= value_i;
                pend_dp_q  <= dp_mask_i;
            end
            act_val_q   <= act_val_d;
            act_dp_q    <= act_dp_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            scan_done_q <= frame_end;
        end
    end

    assign an_o        = an_q;
    assign seg_o       = seg_q;
    assign dp_o        = dp_q;
    assign scan_done_o = scan_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: 4-digit and 3-digit instances checked every cycle against
// a reference model derived from the cycle count since reset.
module tb_seven_seg_scanner;
    localparam int P = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        load, blank_lz;
    logic [1:0]  brightness;

    logic [6:0] seg4, seg3;
    logic       dp4, dp3, sd4, sd3;
    logic [3:0] an4;
    logic [2:0] an3;

    int n_vec = 0;
    int n_err = 0;

    // Model state: edges since reset release and the frame/pending registers per instance.
    int          t;
    logic [15:0] pend4, act4, pend3, act3;
    logic [3:0]  pm4, am4, pm3, am3;

    logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    always #5 clk = ~clk;

    seven_seg_scanner #(.NUM_DIGITS(4), .PRESCALE(P), .BLANK_CYCLES(2), .DIM_WIDTH(2)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .value_i(value), .dp_mask_i(dp_mask), .load_i(load),
        .blank_lz_i(blank_lz), .brightness_i(brightness),
        .seg_o(seg4), .dp_o(dp4), .an_o(an4), .scan_done_o(sd4)
    );

    seven_seg_scanner #(.NUM_DIGITS(3), .PRESCALE(P), .BLANK_CYCLES(2), .DIM_WIDTH(2)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .value_i(value[11:0]), .dp_mask_i(dp_mask[2:0]),
        .load_i(load), .blank_lz_i(blank_lz), .brightness_i(brightness),
        .seg_o(seg3), .dp_o(dp3), .an_o(an3), .scan_done_o(sd3)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected {an[3:0], seg[6:0], dp} for an n-digit display after the edge at count tt.
    function automatic logic [11:0] model_out(int n, int tt, logic [15:0] act, logic [3:0] mask,
                                              logic blz, logic [1:0] br);
        int         p   = tt % P;
        int         idx = (tt / P) % n;
        int         q   = tt % 4;
        logic       pwm = (br == 2'd3) || (q < int'(br));
        logic       blanked = blz && (idx > 0) && ((act >> (4 * idx)) == 16'h0);
        logic       en  = (p >= 2) && pwm && !blanked;
        logic [3:0] an  = 4'hF;
        logic [3:0] d   = 4'((act >> (4 * idx)) & 16'hF);
        logic [6:0] s;
        if (en) an[idx] = 1'b0;
        s = blanked ? 7'h7F : seg_tab[d];
        return {an, s, ~mask[idx]};
    endfunction

    task automatic model_reset();
        t = 0;
        pend4 = '0; act4 = '0; pm4 = '0; am4 = '0;
        pend3 = '0; act3 = '0; pm3 = '0; am3 = '0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_an4"}, 16'(an4), 16'hF);
        chk({tag, "_seg4"}, 16'(seg4), 16'h7F);
        chk({tag, "_dp4"}, 16'(dp4), 16'h1);
        chk({tag, "_sd4"}, 16'(sd4), 16'h0);
        chk({tag, "_an3"}, 16'(an3), 16'h7);
        chk({tag, "_seg3"}, 16'(seg3), 16'h7F);
    endtask

    // One clock: predict from pre-edge state and current inputs, sample #1 after the edge.
    task automatic step();
        logic [11:0] e4, e3;
        logic        b4, b3;
        e4 = model_out(4, t, act4, am4, blank_lz, brightness);
        e3 = model_out(3, t, act3, am3, blank_lz, brightness);
        b4 = (t % P == P - 1) && ((t / P) % 4 == 3);
        b3 = (t % P == P - 1) && ((t / P) % 3 == 2);
        @(posedge clk);
        #1;
        chk("an4", 16'(an4), 16'(e4[11:8]));
        chk("seg4", 16'(seg4), 16'(e4[7:1]));
        chk("dp4", 16'(dp4), 16'(e4[0]));
        chk("sd4", 16'(sd4), 16'(b4));
        chk("an3", 16'({1'b1, an3}), 16'(e3[11:8]));
        chk("seg3", 16'(seg3), 16'(e3[7:1]));
        chk("dp3", 16'(dp3), 16'(e3[0]));
        chk("sd3", 16'(sd3), 16'(b3));
        if (b4) begin act4 = load ? value : pend4; am4 = load ? dp_mask : pm4; end
        if (b3) begin act3 = load ? {4'h0, value[11:0]} : pend3; am3 = load ? {1'b0, dp_mask[2:0]} : pm3; end
        if (load) begin
            pend4 = value; pm4 = dp_mask;
            pend3 = {4'h0, value[11:0]}; pm3 = {1'b0, dp_mask[2:0]};
        end
        t++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] m);
        value = v; dp_mask = m; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; value = '0; dp_mask = '0; load = 1'b0; blank_lz = 1'b0; brightness = 2'd3;
        #12;
        check_reset("por");
        rst = 1'b0;
        model_reset();

        // Basic scan of 1234 at full brightness.
        pulse_load(16'h1234, 4'h0);
        run(80);

        // Mid-frame load during digit 1, then a load on the boundary cycle itself.
        while (!((t / P) % 4 == 1 && t % P == 3)) step();
        pulse_load(16'h5678, 4'h0);
        run(50);
        while (t % (4 * P) != 4 * P - 1) step();
        pulse_load(16'h9ABC, 4'h0);
        run(40);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        pulse_load(16'h0070, 4'h0);
        run(70);
        pulse_load(16'h0000, 4'h0);
        run(70);
        blank_lz = 1'b0;

        // Dimming and decimal-point mask.
        brightness = 2'd1;
        run(40);
        brightness = 2'd0;
        run(40);
        brightness = 2'd3;
        pulse_load(16'hABCD, 4'b0100);
        run(70);

        // Randomised traffic; shifted values exercise leading zeros.
        for (int i = 0; i < 1500; i++) begin
            value   = 16'($urandom >> $urandom_range(0, 31));
            dp_mask = 4'($urandom);
            load    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 99) == 0) brightness = 2'($urandom);
            if ($urandom_range(0, 199) == 0) blank_lz = ~blank_lz;
            step();
        end
        load = 1'b0; blank_lz = 1'b0; brightness = 2'd3;

        // Asynchronous reset while digit 1 is lit.
        pulse_load(16'h1234, 4'h0);
        run(40);
        while (!((t / P) % 4 == 1 && t % P == 4)) step();
        step();
        chk("an_before_rst", 16'(an4), 16'hD);
        #2 rst = 1'b1;
        #1 check_reset("mid");
        #3 rst = 1'b0;
        model_reset();
        pulse_load(16'h4321, 4'h0);
        run(80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
